// File: rtl/speck_decrypt_sequencer_pkg.sv
// Shared types and sizing for the SPECK32/64 multi-round decrypt sequencer.
package speck_decrypt_sequencer_pkg;

    // SPECK32/64 word width and two-word block width.
    localparam int unsigned BLOCK_SIZE = 16;
    localparam int unsigned KEY_SIZE   = 2 * BLOCK_SIZE;

    // Default sequencing parameters.
    localparam int unsigned SEQ_ROUNDS         = 22;
    localparam int unsigned SEQ_FLUSH_CYCLES   = 16;
    localparam int unsigned SEQ_TIMEOUT_CYCLES = 32;
    localparam int unsigned SEQ_RK_AW          = $clog2(SEQ_ROUNDS);

    // Sequencer state encodings.
    typedef enum logic [2:0] {
        SEQ_FLUSH = 3'd0,
        SEQ_IDLE  = 3'd1,
        SEQ_FETCH = 3'd2,
        SEQ_START = 3'd3,
        SEQ_WAIT  = 3'd4,
        SEQ_DONE  = 3'd5
    } seq_state_e;

    // Two-word block: hi is the upper half (c1 / x), lo the lower half (c0 / y).
    typedef struct packed {
        logic [BLOCK_SIZE-1:0] hi;
        logic [BLOCK_SIZE-1:0] lo;
    } speck_block_t;

endpackage

// File: rtl/speck_decrypt_sequencer_if.sv
// Host, round-key memory and round-module signals of the decrypt sequencer.
interface speck_decrypt_sequencer_if;
    import speck_decrypt_sequencer_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    speck_block_t          in_data;
    logic                  out_valid;
    logic                  out_ready;
    speck_block_t          out_data;
    logic                  rk_rd_en;
    logic [SEQ_RK_AW-1:0]  rk_addr;
    logic [BLOCK_SIZE-1:0] rk_data;
    logic                  rnd_start;
    logic [BLOCK_SIZE-1:0] rnd_subkey;
    speck_block_t          rnd_in;
    logic                  rnd_finished;
    speck_block_t          rnd_out;
    logic                  error;

    // Sequencer side.
    modport master (
        input  in_valid, in_data, out_ready, rk_data, rnd_finished, rnd_out,
        output in_ready, out_valid, out_data, rk_rd_en, rk_addr,
               rnd_start, rnd_subkey, rnd_in, error
    );

    // Host / memory / round-module side.
    modport slave (
        output in_valid, in_data, out_ready, rk_data, rnd_finished, rnd_out,
        input  in_ready, out_valid, out_data, rk_rd_en, rk_addr,
               rnd_start, rnd_subkey, rnd_in, error
    );

endinterface

// File: rtl/speck_decrypt_sequencer_rise_detect.sv
// 1-bit rising-edge detector with a registered previous value.
// clr_i marks the input as already high, so a level that is still high
// from an earlier event cannot be reported as a new edge.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic d_i,
    output logic rise_c_o
);

    logic prev_q;

    // Track previous input value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else if (clr_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_c_o = d_i & ~prev_q;

endmodule

// File: rtl/speck_decrypt_sequencer.sv
// Multi-round SPECK32/64 decrypt controller: accepts a ciphertext block,
// drives the shared round_decrypt module once per round with subkeys read
// in reverse order, and returns the plaintext on a valid/ready output.
// Optional watchdog: define DECRYPT_TIMEOUT_EN to abort a round that never
// finishes, raise a sticky error and re-flush.
module speck_decrypt_sequencer
    import speck_decrypt_sequencer_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES   = SEQ_FLUSH_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = SEQ_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    speck_decrypt_sequencer_if.master   bus
);

    localparam int unsigned CNT_MAX = (FLUSH_CYCLES > TIMEOUT_CYCLES) ? FLUSH_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    seq_state_e state_q, state_d;

    // Shared counter: flush drain time, and per-round watchdog when enabled.
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SEQ_RK_AW-1:0]  r_q, r_d;
    speck_block_t          work_q, work_d;
    logic                  rk_pend_q, rk_pend_d;
    logic [BLOCK_SIZE-1:0] subkey_q, subkey_d;

    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    speck_block_t          out_data_q, out_data_d;
    logic                  rk_rd_en_q, rk_rd_en_d;
    logic [SEQ_RK_AW-1:0]  rk_addr_q, rk_addr_d;
    logic                  rnd_start_q, rnd_start_d;
    speck_block_t          rnd_in_q, rnd_in_d;

`ifdef DECRYPT_TIMEOUT_EN
    logic                  error_q, error_d;
`endif

    logic fin_clr;
    logic fin_rise;

    // Completion is taken only from a fresh rising edge of rnd_finished.
    rise_detect u_fin_rise (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (fin_clr),
        .d_i      (bus.rnd_finished),
        .rise_c_o (fin_rise)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_FLUSH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        work_d    = work_q;
        rk_pend_d = 1'b0;
        subkey_d  = subkey_q;
        fin_clr   = 1'b0;
`ifdef DECRYPT_TIMEOUT_EN
        error_d   = error_q;
`endif
        unique case (state_q)
            SEQ_FLUSH: begin
                if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = SEQ_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SEQ_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    work_d  = bus.in_data;
                    r_d     = SEQ_RK_AW'(SEQ_ROUNDS - 1);
                    state_d = SEQ_FETCH;
                end
            end
            SEQ_FETCH: begin
                // First cycle issues the read, second cycle sees the key.
                if (!rk_pend_q) begin
                    rk_pend_d = 1'b1;
                end else begin
                    subkey_d = bus.rk_data;
                    state_d  = SEQ_START;
                end
            end
            SEQ_START: begin
                fin_clr = 1'b1;
                cnt_d   = '0;
                state_d = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                if (fin_rise) begin
                    work_d = bus.rnd_out;
                    cnt_d  = '0;
                    if (r_q == '0) begin
                        state_d = SEQ_DONE;
                    end else begin
                        r_d     = r_q - SEQ_RK_AW'(1);
                        state_d = SEQ_FETCH;
                    end
                end
`ifdef DECRYPT_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    cnt_d   = '0;
                    state_d = SEQ_FLUSH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            SEQ_DONE: begin
                if (bus.out_ready) begin
                    state_d = SEQ_IDLE;
                end
            end
            default: begin
                state_d = SEQ_FLUSH;
            end
        endcase
    end

    // Registered output values, derived from the state being entered.
    always_comb begin
        in_ready_d  = (state_d == SEQ_IDLE);
        out_valid_d = (state_d == SEQ_DONE);
        out_data_d  = out_data_q;
        if (state_d == SEQ_DONE) begin
            out_data_d = work_d;
        end
        rk_rd_en_d  = (state_d == SEQ_FETCH) && !rk_pend_d;
        rk_addr_d   = rk_addr_q;
        if (state_d == SEQ_FETCH) begin
            rk_addr_d = r_d;
        end
        rnd_start_d = (state_d == SEQ_START);
        rnd_in_d    = rnd_in_q;
        if (state_d == SEQ_START) begin
            rnd_in_d = work_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            r_q         <= '0;
            work_q      <= '0;
            rk_pend_q   <= 1'b0;
            subkey_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rk_rd_en_q  <= 1'b0;
            rk_addr_q   <= '0;
            rnd_start_q <= 1'b0;
            rnd_in_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            work_q      <= work_d;
            rk_pend_q   <= rk_pend_d;
            subkey_q    <= subkey_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rk_rd_en_q  <= rk_rd_en_d;
            rk_addr_q   <= rk_addr_d;
            rnd_start_q <= rnd_start_d;
            rnd_in_q    <= rnd_in_d;
        end
    end

`ifdef DECRYPT_TIMEOUT_EN
    // Sticky watchdog flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end
    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.rk_rd_en   = rk_rd_en_q;
    assign bus.rk_addr    = rk_addr_q;
    assign bus.rnd_start  = rnd_start_q;
    assign bus.rnd_subkey = subkey_q;
    assign bus.rnd_in     = rnd_in_q;

endmodule

// File: tb/tb_speck_decrypt_sequencer.sv
// Bench for speck_decrypt_sequencer: behavioural round-key memory and
// round_decrypt stand-in, SPECK32/64 encryption as the reference.
module tb_speck_decrypt_sequencer;
    import speck_decrypt_sequencer_pkg::*;

    localparam int unsigned R  = SEQ_ROUNDS;
    localparam int unsigned FL = SEQ_FLUSH_CYCLES;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    speck_decrypt_sequencer_if bus ();

    speck_decrypt_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference arithmetic ----------------
    logic [15:0] rk_mem [0:R-1];

    function automatic logic [15:0] ror16(input logic [15:0] v, input int unsigned s);
        return (v >> s) | (v << (16 - s));
    endfunction

    function automatic logic [15:0] rol16(input logic [15:0] v, input int unsigned s);
        return (v << s) | (v >> (16 - s));
    endfunction

    task automatic load_key(input logic [63:0] key);
        logic [15:0] l [0:R+1];
        logic [15:0] k;
        k    = key[15:0];
        l[0] = key[31:16];
        l[1] = key[47:32];
        l[2] = key[63:48];
        for (int i = 0; i < int'(R); i++) begin
            rk_mem[i] = k;
            if (i < int'(R) - 1) begin
                l[i+3] = (k + ror16(l[i], 7)) ^ 16'(i);
                k      = rol16(k, 2) ^ l[i+3];
            end
        end
    endtask

    function automatic logic [31:0] encrypt(input logic [31:0] pt);
        logic [15:0] x, y;
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < int'(R); i++) begin
            x = (ror16(x, 7) + y) ^ rk_mem[i];
            y = rol16(y, 2) ^ x;
        end
        return {x, y};
    endfunction

    function automatic logic [31:0] dec_round(input logic [31:0] c, input logic [15:0] k);
        logic [15:0] x, y;
        x = c[31:16];
        y = c[15:0];
        y = ror16(y ^ x, 2);
        x = rol16((x ^ k) - y, 7);
        return {x, y};
    endfunction

    // ---------------- round-key memory: data one cycle after read ----------------
    logic [15:0] rk_q = '0;
    int          addr_log [$];
    assign bus.rk_data = rk_q;

    always @(posedge clk) begin
        if (bus.rk_rd_en) begin
            rk_q <= rk_mem[bus.rk_addr];
            addr_log.push_back(int'(bus.rk_addr));
        end else begin
            rk_q <= 16'($urandom);
        end
    end

    // ---------------- round_decrypt stand-in (no reset) ----------------
    int unsigned lr    = 2;
    bit          hang  = 1'b0;
    bit          stale = 1'b0;
    bit          busy  = 1'b0;
    int unsigned rcnt  = 0;
    logic        fin_m = 1'b0;
    logic [31:0] out_m = '0;
    assign bus.rnd_finished = fin_m;
    assign bus.rnd_out      = out_m;

    always @(posedge clk) begin
        if (bus.rnd_start) begin
            fin_m <= 1'b0;
            busy  <= 1'b1;
            rcnt  <= lr;
        end else if (busy && !hang) begin
            if (rcnt <= 1) begin
                fin_m <= 1'b1;
                out_m <= dec_round(bus.rnd_in, bus.rnd_subkey);
                busy  <= 1'b0;
            end else begin
                rcnt <= rcnt - 1;
            end
        end else if (!busy && stale) begin
            fin_m <= 1'b1;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready",   64'(bus.in_ready),   64'd0);
        check("rst_out_valid",  64'(bus.out_valid),  64'd0);
        check("rst_out_data",   64'(bus.out_data),   64'd0);
        check("rst_rk_rd_en",   64'(bus.rk_rd_en),   64'd0);
        check("rst_rk_addr",    64'(bus.rk_addr),    64'd0);
        check("rst_rnd_start",  64'(bus.rnd_start),  64'd0);
        check("rst_rnd_subkey", 64'(bus.rnd_subkey), 64'd0);
        check("rst_rnd_in",     64'(bus.rnd_in),     64'd0);
        check("rst_error",      64'(bus.error),      64'd0);
    endtask

    // Assert reset asynchronously now, release it, then check the drain time.
    task automatic reset_dut();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= int'(FL); i++) begin
            @(posedge clk);
            #1;
            check("flush_in_ready", 64'(bus.in_ready), 64'(i == int'(FL)));
        end
    endtask

    // Offer a block; returns once the accepting edge has passed.
    task automatic accept(input logic [31:0] ct);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = ct;
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen.
    task automatic wait_out(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!bus.out_valid && edges < 5000);
        if (!bus.out_valid) check("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hs_out_valid_drop", 64'(bus.out_valid), 64'd0);
        check("hs_in_ready_back",  64'(bus.in_ready),  64'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_block(input string tag, input logic [31:0] ct, input logic [31:0] pt,
                             input int unsigned l);
        int e;
        lr = l;
        accept(ct);
        wait_out(e);
        check({tag, "_latency"}, 64'(e + 1), 64'(R * (l + 4) + 1));
        check({tag, "_data"}, 64'(bus.out_data), 64'(pt));
        check({tag, "_in_ready_in_done"}, 64'(bus.in_ready), 64'd0);
        handshake();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] pt_a, pt_b, ct_a, ct_b;
        int          e;
        bit          found;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Power-on reset and drain.
        reset_dut();

        // Known-answer test with reverse key order.
        load_key(64'h1918_1110_0908_0100);
        addr_log.delete();
        run_block("kat", 32'ha868_42f2, 32'h6574_694c, 2);
        check("kat_addr_count", 64'(addr_log.size()), 64'(R));
        for (int i = 0; i < addr_log.size() && i < int'(R); i++) begin
            check("kat_addr_order", 64'(addr_log[i]), 64'(int'(R) - 1 - i));
        end

        // Random keys, plaintexts and round latencies.
        for (int n = 0; n < 4; n++) begin
            load_key({$urandom, $urandom});
            pt_a = $urandom;
            run_block("rand", encrypt(pt_a), pt_a, $urandom_range(1, 6));
        end

        // Back-to-back with in_valid held during DONE and 50 cycles of backpressure.
        load_key({$urandom, $urandom});
        pt_a = $urandom;
        pt_b = $urandom;
        ct_a = encrypt(pt_a);
        ct_b = encrypt(pt_b);
        lr = 3;
        accept(ct_a);
        wait_out(e);
        check("b2b_a_latency", 64'(e + 1), 64'(R * (3 + 4) + 1));
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = ct_b;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_out_data",  64'(bus.out_data),  64'(pt_a));
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
            check("bp_no_fetch",  64'(bus.rk_rd_en),  64'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_out_valid_drop", 64'(bus.out_valid), 64'd0);
        check("b2b_in_ready_idle",  64'(bus.in_ready),  64'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("b2b_b_accepted_rd", 64'(bus.rk_rd_en), 64'd1);
        check("b2b_b_accepted_rdy", 64'(bus.in_ready), 64'd0);
        wait_out(e);
        check("b2b_b_latency", 64'(e + 1), 64'(R * (3 + 4) + 1));
        check("b2b_b_data", 64'(bus.out_data), 64'(pt_b));
        handshake();

        // Reset in the middle of round 10 (key index 10).
        pt_a = $urandom;
        lr = 3;
        accept(encrypt(pt_a));
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (bus.rk_rd_en && bus.rk_addr == SEQ_RK_AW'(10)) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_reset_reached_round", 64'(found), 64'd1);
        @(posedge clk);
        #3;
        reset_dut();
        pt_a = $urandom;
        run_block("after_reset", encrypt(pt_a), pt_a, 2);

        // Stale finished level before the first start.
        stale = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("stale_fin_high", 64'(bus.rnd_finished), 64'd1);
        pt_a = $urandom;
        run_block("stale", encrypt(pt_a), pt_a, 4);
        stale = 1'b0;

`ifdef DECRYPT_TIMEOUT_EN
        // Round module never finishes: watchdog aborts after the WAIT budget.
        hang = 1'b1;
        lr = 2;
        accept(32'h1234_5678);
        e = 0;
        while (!bus.rnd_start && e < 100) begin
            @(posedge clk);
            #1;
            e++;
        end
        check("to_start_seen", 64'(bus.rnd_start), 64'd1);
        e = 0;
        do begin
            @(posedge clk);
            #1;
            e++;
            if (!bus.error) check("to_no_out_valid", 64'(bus.out_valid), 64'd0);
        end while (!bus.error && e < 200);
        check("to_wait_cycles", 64'(e - 1), 64'(SEQ_TIMEOUT_CYCLES));
        check("to_error", 64'(bus.error), 64'd1);
        check("to_out_valid", 64'(bus.out_valid), 64'd0);
        check("to_in_ready_flush", 64'(bus.in_ready), 64'd0);
        hang = 1'b0;
        for (int i = 1; i <= int'(FL); i++) begin
            @(posedge clk);
            #1;
            check("to_flush_in_ready", 64'(bus.in_ready), 64'(i == int'(FL)));
            check("to_out_valid_low", 64'(bus.out_valid), 64'd0);
        end
        check("to_error_sticky", 64'(bus.error), 64'd1);
`else
        check("error_tied_low", 64'(bus.error), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #2000000;
        $display("FAIL global_watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
